pop_phase_sequencer: RTL and testbench

Programmable phase sequencer for the POP timing cycle. It steps through up to 8 timing phases, each with its own duration and output-gate pattern. Phase durations are counted in `tick` strobes produced by the slow clock divider. It drives the laser, microwave and photodetector gate lines, and it replaces the free-running fixed-length state counter with a start/stop controlled, register-configured schedule.

---
 rtl/pop_timing_pkg.sv | 25 ++
 rtl/pop_phase_sequencer_phase_timer.sv | 44 ++++
 rtl/pop_phase_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_pop_phase_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pop_timing_pkg.sv
// -----------------------------------------------------------------------------
// pop_timing_pkg
// Shared definitions for the POP timing-cycle sequencer: the sequencer state
// encoding, phase-index sizing and the bit positions of the three gate lines
// inside a phase mask.
// No ports (package).
// -----------------------------------------------------------------------------
package pop_timing_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } seqState_e;

  localparam int PHASE_W    = 3;
  localparam int MAX_PHASES = 8;
  localparam int GATE_W     = 3;

  // Bit positions inside a phase mask, packed as {pd_gate, mw_en, laser_en}
  localparam int LASER = 0;
  localparam int MW    = 1;
  localparam int PD    = 2;

endpackage

// File: rtl/pop_phase_sequencer_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter that times one sequencer phase in timebase ticks.
// A load always wins over counting; otherwise each tick decrements until the
// count reaches zero, where it holds. o_expired flags the tick that finds the
// count already at zero, i.e. the last tick of a phase loaded with dur.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset (count -> 0)
//   i_load     load i_loadVal into the counter
//   i_loadVal  phase duration (phase lasts i_loadVal+1 ticks)
//   i_tick     timebase strobe, already qualified by the caller
//   o_expired  count==0 && i_tick (combinational)
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_W = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_loadVal,
  input  logic             i_tick,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;
  logic             w_atZero;

  assign w_atZero  = (r_count == '0);
  assign o_expired = i_tick && w_atZero;

  // Counter register: load has priority, and it never decrements below zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_tick && !w_atZero) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pop_phase_sequencer.sv
// -----------------------------------------------------------------------------
// pop_phase_sequencer
// Start/stop controlled sequencer that steps through PHASES timing phases of
// the POP cycle. Each phase has a programmable duration (in divider ticks) and
// a gate pattern driving the laser, microwave and photodetector gate lines.
//
// Parameters:
//   PHASES  number of active phases, 1..8
//   CNT_W   width of each phase duration register
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_tick             single-cycle timebase strobe
//   i_start, i_stop    begin a run / finish the current cycle then idle
//   i_cfg_we           configuration write strobe
//   i_cfg_addr         phase index for the write (>= PHASES is ignored)
//   i_cfg_dur          phase duration (phase lasts dur+1 ticks)
//   i_cfg_mask         gate pattern {pd_gate, mw_en, laser_en}
//   o_phase            current phase index
//   o_laser_en, o_mw_en, o_pd_gate   registered gate lines
//   o_busy             high in RUN or STOPPING
//   o_cycle_done       one-cycle pulse after the last phase expires
// -----------------------------------------------------------------------------
module pop_phase_sequencer
  import pop_timing_pkg::*;
#(
  parameter int PHASES = 4,
  parameter int CNT_W  = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_cfg_we,
  input  logic [PHASE_W-1:0] i_cfg_addr,
  input  logic [CNT_W-1:0]   i_cfg_dur,
  input  logic [GATE_W-1:0]  i_cfg_mask,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_laser_en,
  output logic               o_mw_en,
  output logic               o_pd_gate,
  output logic               o_busy,
  output logic               o_cycle_done
);

  seqState_e          r_state;
  seqState_e          w_nextState;

  logic [CNT_W-1:0]   r_durBank  [PHASES];
  logic [GATE_W-1:0]  r_maskBank [PHASES];

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_nextPhase;
  logic [GATE_W-1:0]  r_gates;
  logic [GATE_W-1:0]  w_nextGates;
  logic               r_cycleDone;
  logic               w_nextCycleDone;

  logic               w_timerTick;
  logic               w_expired;
  logic               w_load;
  logic               w_lastPhase;
  logic               w_lastExpire;
  logic [PHASE_W-1:0] w_loadIdx;
  logic [CNT_W-1:0]   w_loadDur;
  logic [GATE_W-1:0]  w_loadMask;

  // Ticks only count while a run is active; the start cycle loads instead
  assign w_timerTick  = i_tick && (r_state != IDLE);
  assign w_lastPhase  = (r_phase == PHASE_W'(PHASES - 1));
  assign w_lastExpire = w_expired && w_lastPhase;

  // Index of the phase that would be loaded next: phase 0 on start or wrap
  assign w_loadIdx = ((r_state == IDLE) || w_lastPhase) ? '0 : r_phase + PHASE_W'(1);

  // Read the bank entry for the phase about to be loaded
  always_comb begin
    w_loadDur  = '0;
    w_loadMask = '0;
    for (int i = 0; i < PHASES; i++) begin
      if (w_loadIdx == PHASE_W'(i)) begin
        w_loadDur  = r_durBank[i];
        w_loadMask = r_maskBank[i];
      end
    end
  end

  // Configuration bank; addresses at or beyond PHASES match no entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < PHASES; i++) begin
        r_durBank[i]  <= '0;
        r_maskBank[i] <= '0;
      end
    end else if (i_cfg_we) begin
      for (int i = 0; i < PHASES; i++) begin
        if (i_cfg_addr == PHASE_W'(i)) begin
          r_durBank[i]  <= i_cfg_dur;
          r_maskBank[i] <= i_cfg_mask;
        end
      end
    end
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_loadVal (w_loadDur),
    .i_tick    (w_timerTick),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: a stop raised on the wrapping tick still lets the new cycle run
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (i_stop) begin
          w_nextState = STOPPING;
        end
      end
      STOPPING: begin
        if (w_lastExpire) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Next output values and timer load; the final expiry while stopping clears gates
  always_comb begin
    w_nextPhase     = r_phase;
    w_nextGates     = r_gates;
    w_nextCycleDone = 1'b0;
    w_load          = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextPhase = '0;
          w_nextGates = w_loadMask;
          w_load      = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (w_expired) begin
          w_nextCycleDone = w_lastPhase;
          if ((r_state == STOPPING) && w_lastPhase) begin
            w_nextPhase = '0;
            w_nextGates = '0;
          end else begin
            w_nextPhase = w_loadIdx;
            w_nextGates = w_loadMask;
            w_load      = 1'b1;
          end
        end
      end
      default: begin
        w_nextPhase = '0;
        w_nextGates = '0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase     <= '0;
      r_gates     <= '0;
      r_cycleDone <= 1'b0;
    end else begin
      r_phase     <= w_nextPhase;
      r_gates     <= w_nextGates;
      r_cycleDone <= w_nextCycleDone;
    end
  end

  assign o_phase      = r_phase;
  assign o_laser_en   = r_gates[LASER];
  assign o_mw_en      = r_gates[MW];
  assign o_pd_gate    = r_gates[PD];
  assign o_busy       = (r_state != IDLE);
  assign o_cycle_done = r_cycleDone;

endmodule

// File: tb/tb_pop_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pop_phase_sequencer
// Self-checking bench: a 4-phase instance driven against a tick-level model
// whose per-cycle expectations go through a scoreboard queue, plus a 1-phase
// instance with directed expectations.
// -----------------------------------------------------------------------------
module tb_pop_phase_sequencer;

  localparam int NPH = 4;

  typedef struct packed {
    logic [2:0] phase;
    logic [2:0] gates;
    logic       busy;
    logic       cdone;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-phase instance
  logic        rst = 1'b1, tick = 1'b0, start = 1'b0, stop = 1'b0, cfgWe = 1'b0;
  logic [2:0]  cfgAddr = '0, cfgMask = '0;
  logic [19:0] cfgDur = '0;
  logic [2:0]  phase;
  logic        laserEn, mwEn, pdGate, busy, cycleDone;

  // 1-phase instance
  logic        rst1 = 1'b1, tick1 = 1'b0, start1 = 1'b0, stop1 = 1'b0, cfgWe1 = 1'b0;
  logic [2:0]  cfgAddr1 = '0, cfgMask1 = '0;
  logic [7:0]  cfgDur1 = '0;
  logic [2:0]  phase1;
  logic        laserEn1, mwEn1, pdGate1, busy1, cycleDone1;

  pop_phase_sequencer #(.PHASES(NPH), .CNT_W(20)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_start(start), .i_stop(stop),
    .i_cfg_we(cfgWe), .i_cfg_addr(cfgAddr), .i_cfg_dur(cfgDur), .i_cfg_mask(cfgMask),
    .o_phase(phase), .o_laser_en(laserEn), .o_mw_en(mwEn), .o_pd_gate(pdGate),
    .o_busy(busy), .o_cycle_done(cycleDone)
  );

  pop_phase_sequencer #(.PHASES(1), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_tick(tick1), .i_start(start1), .i_stop(stop1),
    .i_cfg_we(cfgWe1), .i_cfg_addr(cfgAddr1), .i_cfg_dur(cfgDur1), .i_cfg_mask(cfgMask1),
    .o_phase(phase1), .o_laser_en(laserEn1), .o_mw_en(mwEn1), .o_pd_gate(pdGate1),
    .o_busy(busy1), .o_cycle_done(cycleDone1)
  );

  expT q4[$];
  expT q1[$];
  int  errors = 0;
  int  checks = 0;
  int  cdoneSeen = 0;

  // Reference model: ticks left in the current phase, counted down to zero
  int         mState = 0;
  int         mPhase = 0;
  int         mLeft  = 0;
  logic [2:0] mGates = '0;
  logic       mCdone = 1'b0;
  int         mDur  [NPH];
  logic [2:0] mMask [NPH];

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic expT mkExp(input int ph, input logic [2:0] g, input logic b, input logic c);
    expT e;
    e.phase = ph[2:0];
    e.gates = g;
    e.busy  = b;
    e.cdone = c;
    return e;
  endfunction

  task automatic modelStep(input logic r, input logic tk, input logic st, input logic sp,
                           input logic we, input logic [2:0] ad, input logic [19:0] du,
                           input logic [2:0] mk);
    int ns;
    if (r) begin
      mState = 0; mPhase = 0; mLeft = 0; mGates = '0; mCdone = 1'b0;
      for (int i = 0; i < NPH; i++) begin
        mDur[i]  = 0;
        mMask[i] = '0;
      end
    end else begin
      ns     = mState;
      mCdone = 1'b0;
      if (mState == 0) begin
        if (st) begin
          ns = 1; mPhase = 0; mLeft = mDur[0] + 1; mGates = mMask[0];
        end
      end else begin
        if (mState == 1 && sp) ns = 2;
        if (tk) begin
          mLeft--;
          if (mLeft == 0) begin
            if (mPhase < NPH - 1) begin
              mPhase++;
              mLeft  = mDur[mPhase] + 1;
              mGates = mMask[mPhase];
            end else begin
              mCdone = 1'b1;
              if (mState == 1) begin
                mPhase = 0; mLeft = mDur[0] + 1; mGates = mMask[0];
              end else begin
                ns = 0; mPhase = 0; mGates = '0;
              end
            end
          end
        end
      end
      mState = ns;
      if (we && int'(ad) < NPH) begin
        mDur[ad]  = int'(du);
        mMask[ad] = mk;
      end
    end
  endtask

  task automatic compareCycle();
    expT e;
    checkOutput("sbDepth", 32'(q4.size()), 32'd1);
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checkOutput("phase", 32'(phase), 32'(e.phase));
      checkOutput("gates", 32'({pdGate, mwEn, laserEn}), 32'(e.gates));
      checkOutput("busy", 32'(busy), 32'(e.busy));
      checkOutput("cycleDone", 32'(cycleDone), 32'(e.cdone));
    end
    if (cycleDone) cdoneSeen++;
  endtask

  task automatic applyStimulus(input logic r, input logic tk, input logic st, input logic sp,
                               input logic we, input logic [2:0] ad, input logic [19:0] du,
                               input logic [2:0] mk);
    @(negedge clk);
    rst = r; tick = tk; start = st; stop = sp;
    cfgWe = we; cfgAddr = ad; cfgDur = du; cfgMask = mk;
    modelStep(r, tk, st, sp, we, ad, du, mk);
    q4.push_back(mkExp(mPhase, mGates, (mState != 0), mCdone));
    @(posedge clk);
    #1;
    compareCycle();
  endtask

  task automatic idleCycle(input logic tk);
    applyStimulus(1'b0, tk, 1'b0, 1'b0, 1'b0, 3'd0, 20'd0, 3'd0);
  endtask

  task automatic runTicks(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < period - 1; j++) idleCycle(1'b0);
      idleCycle(1'b1);
    end
  endtask

  task automatic cfgWrite(input logic [2:0] ad, input logic [19:0] du, input logic [2:0] mk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ad, du, mk);
  endtask

  task automatic applyStim1(input logic r, input logic tk, input logic st, input logic we,
                            input logic [2:0] ad, input logic [7:0] du, input logic [2:0] mk,
                            input expT e);
    expT got;
    @(negedge clk);
    rst1 = r; tick1 = tk; start1 = st; stop1 = 1'b0;
    cfgWe1 = we; cfgAddr1 = ad; cfgDur1 = du; cfgMask1 = mk;
    q1.push_back(e);
    @(posedge clk);
    #1;
    checkOutput("p1Depth", 32'(q1.size()), 32'd1);
    if (q1.size() > 0) begin
      got = q1.pop_front();
      checkOutput("p1Phase", 32'(phase1), 32'(got.phase));
      checkOutput("p1Gates", 32'({pdGate1, mwEn1, laserEn1}), 32'(got.gates));
      checkOutput("p1Busy", 32'(busy1), 32'(got.busy));
      checkOutput("p1CycleDone", 32'(cycleDone1), 32'(got.cdone));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset and basic four-phase cycle, tick every 4 clocks
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 20'd0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 20'd0, 3'd0);
    cfgWrite(3'd0, 20'd2, 3'd1);
    cfgWrite(3'd1, 20'd0, 3'd3);
    cfgWrite(3'd2, 20'd1, 3'd4);
    cfgWrite(3'd3, 20'd3, 3'd0);
    cdoneSeen = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 20'd0, 3'd0);
    runTicks(12, 4);
    checkOutput("oneCdonePerCycle", 32'(cdoneSeen), 32'd1);

    // Stop requested during phase 1 finishes the cycle then idles
    runTicks(1, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 20'd0, 3'd0);
    cdoneSeen = 0;
    runTicks(12, 4);
    checkOutput("stopNoSecondCycle", 32'(cdoneSeen), 32'd1);

    // start+stop+tick together in IDLE
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 20'd0, 3'd0);
    runTicks(2, 1);
    runTicks(1, 1);

    // Rewrite dur[1] while phase 1 runs with count 0; out-of-range write ignored
    cfgWrite(3'd1, 20'd5, 3'd3);
    cfgWrite(3'd6, 20'd7, 3'd7);
    runTicks(17, 2);

    // Reset in the middle of phase 2 with laser gate on
    cfgWrite(3'd2, 20'd1, 3'd5);
    runTicks(14, 1);
    runTicks(1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 20'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 20'd0, 3'd0);
    runTicks(6, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 20'd0, 3'd0);
    runTicks(3, 1);

    // Single-phase instance with dur=0: cycle_done on every tick
    applyStim1(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, mkExp(0, 3'd0, 1'b0, 1'b0));
    applyStim1(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 3'd5, mkExp(0, 3'd0, 1'b0, 1'b0));
    applyStim1(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd3, 3'd7, mkExp(0, 3'd0, 1'b0, 1'b0));
    applyStim1(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 3'd0, mkExp(0, 3'd5, 1'b1, 1'b0));
    for (int k = 0; k < 5; k++) begin
      applyStim1(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, mkExp(0, 3'd5, 1'b1, 1'b1));
    end
    applyStim1(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, mkExp(0, 3'd5, 1'b1, 1'b0));
    applyStim1(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, mkExp(0, 3'd5, 1'b1, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
